// File: rtl/acc_mac_pkg.sv
// Shared constants and types for the custom-0 accelerator responder.
// Pure declarations; no logic, no latency, no flow control.
package acc_mac_pkg;

    localparam logic [6:0] AccOpcode = 7'b0001011;

    typedef enum logic [2:0] {
        FnAdd = 3'd0,
        FnSub = 3'd1,
        FnMac = 3'd2
    } funct_e;

    typedef enum logic {
        Idle = 1'b0,
        Exec = 1'b1
    } state_e;

    // Packed width of a response entry {data, id, error}.
    function automatic int resp_width(input int data_w, input int id_w);
        return data_w + id_w + 1;
    endfunction

endpackage

// File: rtl/acc_mac_responder_if.sv
// Request (Q) / response (P) channels of the accelerator bus.
// Valid/ready on both channels; the master drives Q and sinks P.
interface acc_mac_responder_if #(
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned AccAddrWidth = 5,
    parameter int unsigned IdWidth      = 5
);
    logic [AccAddrWidth-1:0] q_addr;
    logic [31:0]             q_data_op;
    logic [DataWidth-1:0]    q_data_arga;
    logic [DataWidth-1:0]    q_data_argb;
    logic [DataWidth-1:0]    q_data_argc;
    logic [IdWidth-1:0]      q_id;
    logic                    q_valid;
    logic                    q_ready;

    logic [DataWidth-1:0]    p_data;
    logic [IdWidth-1:0]      p_id;
    logic                    p_error;
    logic                    p_valid;
    logic                    p_ready;

    modport master (
        output q_addr, q_data_op, q_data_arga, q_data_argb, q_data_argc, q_id, q_valid,
        input  q_ready,
        input  p_data, p_id, p_error, p_valid,
        output p_ready
    );

    modport slave (
        input  q_addr, q_data_op, q_data_arga, q_data_argb, q_data_argc, q_id, q_valid,
        output q_ready,
        output p_data, p_id, p_error, p_valid,
        input  p_ready
    );

endinterface

// File: rtl/acc_resp_fifo.sv
// Non-fallthrough response FIFO: head is registered storage, zero while empty.
// Push lands in the cycle after the edge; pop on a non-empty FIFO; push on full only with a pop.
module acc_resp_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic [Width-1:0] wdata,
    input  logic             pop,
    output logic [Width-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  cnt_q;
    logic             push_ok, pop_ok;

    // Wrap explicitly so non-power-of-two depths work.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CntW'(Depth));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = empty ? '0 : mem[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop_ok) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push_ok && !pop_ok) begin
                cnt_q <= cnt_q + CntW'(1);
            end else if (pop_ok && !push_ok) begin
                cnt_q <= cnt_q - CntW'(1);
            end
        end
    end

endmodule

// File: rtl/acc_mac_responder.sv
// Executes offloaded custom-0 ADD/SUB/MAC and returns in-order responses via a FIFO.
// ADD/SUB/error: response 2 cycles after accept, MAC: DataWidth+1; Q stalls while busy or FIFO full.
module acc_mac_responder
    import acc_mac_pkg::*;
#(
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned AccAddrWidth = 5,
    parameter int unsigned IdWidth      = 5,
    parameter int unsigned AccAddr      = 0,
    parameter int unsigned RespDepth    = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    acc_mac_responder_if.slave bus
);
    localparam int unsigned CntW  = $clog2(DataWidth);
    localparam int unsigned RespW = resp_width(DataWidth, IdWidth);

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic [IdWidth-1:0]   id;
        logic                 error;
    } resp_t;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q;
    logic [DataWidth-1:0] a_q, b_q, acc_q;
    logic [IdWidth-1:0]   id_q;
    funct_e               funct_q;
    logic                 err_q, suppress_q;

    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic [4:0]           rd;
    logic                 dec_err;
    logic                 unused_op_bits;

    logic                 q_rdy, q_hs, push, last;
    logic [DataWidth-1:0] acc_nxt, result;
    resp_t                push_resp, head;
    logic [RespW-1:0]     fifo_rdata;
    logic                 fifo_full, fifo_empty;

    assign opcode         = bus.q_data_op[6:0];
    assign rd             = bus.q_data_op[11:7];
    assign funct3         = bus.q_data_op[14:12];
    assign unused_op_bits = ^bus.q_data_op[31:15];

    assign dec_err = (opcode != AccOpcode) || (funct3 > 3'd2) ||
                     (bus.q_addr != AccAddrWidth'(AccAddr));

    // One multiplier bit per cycle: b shifts right, a shifts left, accumulator starts at c.
    assign acc_nxt = acc_q + (b_q[0] ? a_q : '0);
    assign last    = err_q || (funct_q != FnMac) || (cnt_q == CntW'(DataWidth - 1));

    always_comb begin
        result = '0;
        if (!err_q) begin
            unique case (funct_q)
                FnAdd:   result = a_q + b_q;
                FnSub:   result = a_q - b_q;
                FnMac:   result = acc_nxt;
                default: result = '0;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        q_rdy   = 1'b0;
        push    = 1'b0;
        unique case (state_q)
            Idle: begin
                q_rdy = rst_ni && !fifo_full;
                if (bus.q_valid && q_rdy) begin
                    state_d = Exec;
                end
            end
            Exec: begin
                if (last) begin
                    push    = !suppress_q;
                    state_d = Idle;
                end
            end
            default: state_d = Idle;
        endcase
    end

    assign bus.q_ready = q_rdy;
    assign q_hs        = bus.q_valid && q_rdy;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= Idle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            id_q       <= '0;
            funct_q    <= FnAdd;
            err_q      <= 1'b0;
            suppress_q <= 1'b0;
        end else if (q_hs) begin
            cnt_q      <= '0;
            a_q        <= bus.q_data_arga;
            b_q        <= bus.q_data_argb;
            acc_q      <= bus.q_data_argc;
            id_q       <= bus.q_id;
            funct_q    <= dec_err ? FnAdd : funct_e'(funct3);
            err_q      <= dec_err;
            suppress_q <= !dec_err && (rd == 5'd0);
        end else if (state_q == Exec && funct_q == FnMac && !err_q) begin
            acc_q <= acc_nxt;
            a_q   <= a_q << 1;
            b_q   <= b_q >> 1;
            cnt_q <= last ? '0 : cnt_q + CntW'(1);
        end
    end

    assign push_resp.data  = result;
    assign push_resp.id    = id_q;
    assign push_resp.error = err_q;

    acc_resp_fifo #(
        .Width (RespW),
        .Depth (RespDepth)
    ) u_resp_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (push),
        .wdata  (push_resp),
        .pop    (bus.p_valid && bus.p_ready),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign head        = fifo_rdata;
    assign bus.p_valid = !fifo_empty;
    assign bus.p_data  = head.data;
    assign bus.p_id    = head.id;
    assign bus.p_error = head.error;

endmodule

// File: tb/tb_acc_mac_responder.sv
// Randomised and directed stimulus against a plain-arithmetic reference model,
// with a scoreboard queue drained by an independent response monitor.
module tb_acc_mac_responder;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int IW    = 5;
    localparam int ADDR  = 0;
    localparam int DEPTH = 2;

    typedef struct {
        logic [DW-1:0] data;
        logic [IW-1:0] id;
        logic          err;
    } exp_t;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    acc_mac_responder_if #(.DataWidth(DW), .AccAddrWidth(AW), .IdWidth(IW)) bus ();

    acc_mac_responder #(
        .DataWidth    (DW),
        .AccAddrWidth (AW),
        .IdWidth      (IW),
        .AccAddr      (ADDR),
        .RespDepth    (DEPTH)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    exp_t exp_q[$];
    int   errors        = 0;
    int   checks        = 0;
    int   cyc           = 0;
    int   n_resp        = 0;
    int   first_pop_cyc = -1;
    int   last_hs_cyc   = 0;
    bit   rand_rdy      = 1'b0;
    bit   pr_force      = 1'b1;

    always @(posedge clk_i) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: what the offloader should get back, straight from the decode rules.
    function automatic bit model(input logic [AW-1:0] addr, input logic [31:0] op,
                                 input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 input logic [DW-1:0] c, input logic [IW-1:0] id,
                                 output exp_t e);
        logic [2:0] f3;
        bit         err;
        f3    = op[14:12];
        err   = (op[6:0] != 7'b0001011) || (f3 > 3'd2) || (addr != AW'(ADDR));
        e.id  = id;
        e.err = err;
        e.data = '0;
        if (!err) begin
            if (f3 == 3'd0)      e.data = a + b;
            else if (f3 == 3'd1) e.data = a - b;
            else                 e.data = a * b + c;
        end
        return err || (op[11:7] != 5'd0);
    endfunction

    function automatic logic [31:0] mk_op(input logic [2:0] f3, input logic [4:0] rd);
        logic [31:0] o;
        o        = $urandom;
        o[14:12] = f3;
        o[11:7]  = rd;
        o[6:0]   = 7'b0001011;
        return o;
    endfunction

    // Called at posedge+1; returns at posedge+1 of the cycle after the handshake.
    task automatic send(input logic [AW-1:0] addr, input logic [31:0] op,
                        input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] c, input logic [IW-1:0] id);
        exp_t e;
        bit   has;
        bit   accepted;
        int   n;
        bus.q_addr      = addr;
        bus.q_data_op   = op;
        bus.q_data_arga = a;
        bus.q_data_argb = b;
        bus.q_data_argc = c;
        bus.q_id        = id;
        bus.q_valid     = 1'b1;
        accepted = 1'b0;
        n = 0;
        while (!accepted && n < 300) begin
            @(negedge clk_i);
            if (bus.q_ready) accepted = 1'b1;
            else n++;
        end
        check("send_accept", 64'(accepted), 64'd1);
        if (accepted) begin
            has = model(addr, op, a, b, c, id, e);
            if (has) exp_q.push_back(e);
            last_hs_cyc = cyc + 1;
        end
        @(posedge clk_i);
        #1;
        bus.q_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(posedge clk_i);
            n++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    task automatic add_latency(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [IW-1:0] id);
        send(AW'(ADDR), mk_op(3'd0, 5'd1), a, b, '0, id);
        @(negedge clk_i);
        check("add_c1_qready", 64'(bus.q_ready), 64'd0);
        check("add_c1_pvalid", 64'(bus.p_valid), 64'd0);
        @(negedge clk_i);
        check("add_c2_pvalid", 64'(bus.p_valid), 64'd1);
        check("add_c2_qready", 64'(bus.q_ready), 64'd1);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        bus.p_ready = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            bus.p_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : pr_force;
        end
    end

    // Response monitor: pops the scoreboard on every P handshake and checks stall stability.
    initial begin
        exp_t                 e;
        bit                   stalled;
        logic [DW-1:0]        h_data;
        logic [IW-1:0]        h_id;
        logic                 h_err;
        stalled = 1'b0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                stalled = 1'b0;
            end else if (bus.p_valid) begin
                if (stalled) begin
                    check("stall_data", 64'(bus.p_data), 64'(h_data));
                    check("stall_id", 64'(bus.p_id), 64'(h_id));
                    check("stall_err", 64'(bus.p_error), 64'(h_err));
                end
                if (bus.p_ready) begin
                    n_resp++;
                    if (first_pop_cyc < 0) first_pop_cyc = cyc + 1;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_resp: got id 0x%0h data 0x%0h, expected none", bus.p_id, bus.p_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("resp_data", 64'(bus.p_data), 64'(e.data));
                        check("resp_id", 64'(bus.p_id), 64'(e.id));
                        check("resp_err", 64'(bus.p_error), 64'(e.err));
                    end
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    h_data  = bus.p_data;
                    h_id    = bus.p_id;
                    h_err   = bus.p_error;
                end
            end else begin
                if (stalled) check("stall_valid_held", 64'(bus.p_valid), 64'd1);
                stalled = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  seen;
        int  base;
        bit  bp_done;
        logic [31:0] op;
        logic [AW-1:0] addr;

        bus.q_valid     = 1'b0;
        bus.q_addr      = '0;
        bus.q_data_op   = '0;
        bus.q_data_arga = '0;
        bus.q_data_argb = '0;
        bus.q_data_argc = '0;
        bus.q_id        = '0;

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_qready", 64'(bus.q_ready), 64'd0);
        check("rst_pvalid", 64'(bus.p_valid), 64'd0);
        check("rst_pdata", 64'(bus.p_data), 64'd0);
        check("rst_pid", 64'(bus.p_id), 64'd0);
        check("rst_perror", 64'(bus.p_error), 64'd0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        add_latency(32'd5, 32'd7, 5'd3);
        drain();

        // MAC latency and Q stall through EXEC
        send(AW'(ADDR), mk_op(3'd2, 5'd1), 32'd3, 32'd4, 32'd10, 5'd9);
        n = 1;
        seen = 1'b0;
        while (n <= 100) begin
            @(negedge clk_i);
            if (bus.p_valid) break;
            if (bus.q_ready) seen = 1'b1;
            n++;
        end
        check("mac_latency", 64'(n), 64'(DW + 1));
        check("mac_qready_low", 64'(seen), 64'd0);
        @(posedge clk_i);
        #1;
        drain();

        send(AW'(ADDR), mk_op(3'd2, 5'd2), 32'hFFFF_FFFF, 32'd2, 32'd1, 5'd2);
        send(AW'(ADDR), mk_op(3'd1, 5'd3), 32'd0, 32'd1, 32'd0, 5'd12);
        send(AW'(ADDR), 32'h0000_0033, 32'd8, 32'd9, 32'd0, 5'd6);
        send(AW'(ADDR + 1), mk_op(3'd0, 5'd1), 32'd8, 32'd9, 32'd0, 5'd7);
        send(AW'(ADDR), mk_op(3'd3, 5'd1), 32'd8, 32'd9, 32'd0, 5'd8);
        drain();

        // Backpressure: FIFO fills with ids 1,2; id 3 waits for the first pop
        pr_force = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        bp_done = 1'b0;
        fork
            begin
                send(AW'(ADDR), mk_op(3'd0, 5'd1), 32'd1, 32'd1, 32'd0, 5'd1);
                send(AW'(ADDR), mk_op(3'd0, 5'd1), 32'd2, 32'd2, 32'd0, 5'd2);
                send(AW'(ADDR), mk_op(3'd0, 5'd1), 32'd3, 32'd3, 32'd0, 5'd3);
                bp_done = 1'b1;
            end
        join_none
        repeat (20) @(negedge clk_i);
        check("bp_qready_low", 64'(bus.q_ready), 64'd0);
        check("bp_accepted", 64'(exp_q.size()), 64'd2);
        check("bp_head_id", 64'(bus.p_id), 64'd1);
        first_pop_cyc = -1;
        pr_force = 1'b1;
        n = 0;
        while (!bp_done && n < 600) begin
            @(posedge clk_i);
            n++;
        end
        check("bp_sender_done", 64'(bp_done), 64'd1);
        #1;
        drain();
        check("bp_id3_after_pop", 64'(last_hs_cyc - first_pop_cyc), 64'd1);

        // rd == 0 suppresses the response
        base = n_resp;
        send(AW'(ADDR), mk_op(3'd0, 5'd0), 32'd1, 32'd2, 32'd0, 5'd4);
        send(AW'(ADDR), mk_op(3'd0, 5'd1), 32'd3, 32'd4, 32'd0, 5'd5);
        drain();
        check("rd0_one_resp", 64'(n_resp - base), 64'd1);

        // Reset in cycle 10 of a MAC discards it
        send(AW'(ADDR), mk_op(3'd2, 5'd1), 32'd7, 32'd9, 32'd1, 5'd13);
        repeat (9) @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        check("mrst_qready", 64'(bus.q_ready), 64'd0);
        check("mrst_pvalid", 64'(bus.p_valid), 64'd0);
        check("mrst_pdata", 64'(bus.p_data), 64'd0);
        check("mrst_pid", 64'(bus.p_id), 64'd0);
        check("mrst_perror", 64'(bus.p_error), 64'd0);
        void'(exp_q.pop_back());
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk_i);
            if (bus.p_valid) seen = 1'b1;
        end
        check("mrst_no_resp", 64'(seen), 64'd0);
        @(posedge clk_i);
        #1;
        add_latency(32'd20, 32'd22, 5'd11);
        drain();

        // Random traffic with random response backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            op = mk_op(3'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            if ($urandom_range(0, 7) == 0) op[6:0] = 7'($urandom);
            addr = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'(ADDR);
            send(addr, op, $urandom, $urandom, $urandom, IW'($urandom));
        end
        rand_rdy = 1'b0;
        pr_force = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
